// File: rtl/rtc_bus_if.sv
// rtc_bus_if: request/response and multiplexed AD-bus signals of the RTC bus stage
interface rtc_bus_if;
    logic       req_rd, req_wr;
    logic [7:0] addr, wdata, rdata;
    logic       busy, done, wr_err;
    logic [7:0] ad_out, ad_in;
    logic       ad_oe, ad_sel, cs_n, rd_n, wr_n;
    modport master (
        output req_rd, req_wr, addr, wdata, ad_in,
        input  rdata, busy, done, wr_err, ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
    );
    modport slave (
        input  req_rd, req_wr, addr, wdata, ad_in,
        output rdata, busy, done, wr_err, ad_out, ad_oe, ad_sel, cs_n, rd_n, wr_n
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: turns single-cycle read/write requests into timed RTC address/data bus cycles
// Optional RTC_BUS_WRITE_VERIFY_EN adds a read-back after every write and flags mismatches on wr_err.
module rtc_bus_ctrl #(
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_PULSE = 8,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_GAP   = 10
) (
    input  logic       clk,
    input  logic       reset,
    rtc_bus_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP} state_t;
    state_t     state, nxt;
    logic [7:0] cnt, nxt_cnt, addr_q, wdata_q, addr_n, wdata_n;
    logic       wr_q, vfy, wr_op_n, vfy_n, rd_op, a_ph, d_ph;

    function automatic logic [7:0] dur(state_t s);
        return s inside {A_SETUP, D_SETUP}  ? 8'(T_SETUP - 1) :
               s inside {A_STROBE, D_STROBE} ? 8'(T_PULSE - 1) :
               s inside {A_HOLD, D_HOLD}     ? 8'(T_HOLD - 1)  :
               s == GAP                      ? 8'(T_GAP - 1)   : 8'd0;
    endfunction

    always_comb begin
        nxt     = state;
        nxt_cnt = cnt - 8'd1;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        wr_op_n = wr_q;
        vfy_n   = vfy;
        if (state == IDLE) begin
            if (bus.req_wr || bus.req_rd) begin
                nxt     = A_SETUP;
                addr_n  = bus.addr;
                wdata_n = bus.wdata;
                wr_op_n = bus.req_wr;
                vfy_n   = 1'b0;
            end
        end else if (cnt == 8'd0) begin
            nxt = state == GAP ? IDLE : state_t'(state + 3'd1);
`ifdef RTC_BUS_WRITE_VERIFY_EN
            if (state == D_HOLD && wr_q && !vfy) begin
                nxt   = A_SETUP;
                vfy_n = 1'b1;
            end
`endif
        end
        if (nxt != state) nxt_cnt = dur(nxt);
        // the verify pass of a write behaves exactly like a read
        rd_op = !wr_op_n || vfy_n;
        a_ph  = nxt inside {A_SETUP, A_STROBE, A_HOLD};
        d_ph  = nxt inside {D_SETUP, D_STROBE, D_HOLD};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            wr_q       <= 1'b0;
            vfy        <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.cs_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            bus.wr_n   <= 1'b1;
            bus.ad_sel <= 1'b0;
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= 8'd0;
            bus.rdata  <= 8'd0;
            bus.wr_err <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= nxt_cnt;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            wr_q       <= wr_op_n;
            vfy        <= vfy_n;
            bus.busy   <= nxt != IDLE;
            bus.done   <= nxt == GAP && state != GAP;
            bus.cs_n   <= !(a_ph || d_ph);
            bus.ad_sel <= d_ph;
            bus.ad_oe  <= a_ph || (d_ph && !rd_op);
            bus.ad_out <= a_ph ? addr_n : d_ph ? wdata_n : 8'd0;
            bus.wr_n   <= !(nxt == A_STROBE || (nxt == D_STROBE && !rd_op));
            bus.rd_n   <= !(nxt == D_STROBE && rd_op);
            if (state == D_STROBE && cnt == 8'd0 && (!wr_q || vfy)) bus.rdata <= bus.ad_in;
`ifdef RTC_BUS_WRITE_VERIFY_EN
            if (nxt == GAP && state != GAP) bus.wr_err <= wr_q && bus.rdata != wdata_q;
`else
            bus.wr_err <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed and randomized checks of rtc_bus_ctrl against a transaction-level model
`timescale 1ns/1ps
module tb_rtc_bus_ctrl;
    localparam int TS = 4, TP = 8, TH = 4, TG = 10, D = TS + TP + TH;
`ifdef RTC_BUS_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int LW = VFY ? 4 * D : 2 * D;
    localparam int LR = 2 * D;

    logic clk = 1'b0, reset = 1'b1;
    rtc_bus_if bus();
    rtc_bus_ctrl #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // RTC chip: latches the address on the address strobe, commits data when a data write strobe completes
    logic [7:0] chip_mem [256];
    logic [7:0] lat = 8'd0, pend_v = 8'd0;
    bit pend = 1'b0, corrupt = 1'b0;
    assign bus.ad_in = !bus.rd_n ? chip_mem[lat] : 8'hA5;
    always @(negedge clk) begin
        if (!bus.cs_n && !bus.wr_n && !bus.ad_sel) lat = bus.ad_out;
        if (!bus.cs_n && !bus.wr_n && bus.ad_sel) begin
            pend   = 1'b1;
            pend_v = corrupt ? bus.ad_out & 8'hFE : bus.ad_out;
        end else if (pend && bus.wr_n) begin
            if (!bus.cs_n) chip_mem[lat] = pend_v;
            pend = 1'b0;
        end
    end

    // reference model: one transaction at a time, described by its accept edge k
    logic [7:0] ref_mem [256];
    int cyc = 0, k = 0, L = 0, lat_o = 0;
    bit m_act = 1'b0, m_wr = 1'b0, m_err = 1'b0;
    logic [7:0] m_a, m_w, m_st, m_new, m_rdata = 8'd0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 1'b0; m_rdata = 8'd0; m_err = 1'b0;
        end else begin
            cyc++;
            if ((!m_act || cyc - 1 - k >= L + TG) && (bus.req_wr || bus.req_rd)) begin
                m_act = 1'b1; k = cyc; m_wr = bus.req_wr; m_a = bus.addr; m_w = bus.wdata;
                m_st  = corrupt ? m_w & 8'hFE : m_w;
                L     = (VFY && m_wr) ? 4 * D : 2 * D;
                lat_o = ((VFY && m_wr) ? 3 * D : D) + TS + TP;
                m_new = m_wr ? m_st : ref_mem[m_a];
            end
            if (m_act && cyc - k == lat_o && (!m_wr || VFY)) m_rdata = m_new;
            if (m_act && cyc - k == L) begin
                if (m_wr) ref_mem[m_a] = m_st;
                m_err = VFY && m_wr && m_st != m_w;
            end
        end
    end

    always @(negedge clk) if (!reset) begin
        int o, p, r;
        bit act, gap, dat, rdp, stb, e_oe;
        o    = cyc - k;
        act  = m_act && o < L;
        gap  = m_act && o >= L && o < L + TG;
        p    = o / D;
        r    = o % D;
        dat  = act && (p % 2 == 1);
        rdp  = !m_wr || p >= 2;
        stb  = act && r >= TS && r < TS + TP;
        e_oe = act && (!dat || !rdp);
        chk("busy", bus.busy, act || gap);
        chk("done", bus.done, gap && o == L);
        chk("cs_n", bus.cs_n, !act);
        chk("ad_sel", bus.ad_sel, dat);
        chk("ad_oe", bus.ad_oe, e_oe);
        chk("wr_n", bus.wr_n, !(stb && (!dat || !rdp)));
        chk("rd_n", bus.rd_n, !(stb && dat && rdp));
        if (e_oe) chk("ad_out", bus.ad_out, dat ? m_w : m_a);
        chk("rdata", bus.rdata, m_rdata);
        chk("wr_err", bus.wr_err, m_err);
    end

    task automatic run_txn(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] w,
                           input int extra_at, input int n,
                           output int wa, output int wd, output int rl, output int rloe, output int dn,
                           output int dat, output int bf, output int csf,
                           output logic [7:0] rdd, output logic erd);
        wa = 0; wd = 0; rl = 0; rloe = 0; dn = 0; dat = -1; bf = -1; csf = -1; rdd = 8'hxx; erd = 1'bx;
        bus.req_wr = wr; bus.req_rd = rd; bus.addr = a; bus.wdata = w;
        @(posedge clk);
        @(negedge clk);
        bus.req_wr = 1'b0; bus.req_rd = 1'b0;
        for (int o = 0; o < n; o++) begin
            if (o > 0) @(negedge clk);
            wa   += int'(!bus.wr_n && !bus.ad_sel && bus.ad_out == a);
            wd   += int'(!bus.wr_n && bus.ad_sel && bus.ad_out == w);
            rl   += int'(!bus.rd_n);
            rloe += int'(!bus.rd_n && bus.ad_oe);
            if (bus.done) begin
                dn++;
                if (dat < 0) begin dat = o; rdd = bus.rdata; erd = bus.wr_err; end
            end
            if (bf < 0 && !bus.busy) bf = o;
            if (csf < 0 && !bus.cs_n) csf = o;
            bus.req_wr = (o == extra_at);
        end
        bus.req_wr = 1'b0;
    endtask

    initial begin
        int wa, wd, rl, rloe, dn, dat, bf, csf, idle_done, rr;
        logic [7:0] rdd;
        logic erd;
        for (int i = 0; i < 256; i++) begin
            chip_mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i]  = chip_mem[i];
        end
        chip_mem[8'h22] = 8'h59;
        ref_mem[8'h22]  = 8'h59;
        bus.req_wr = 1'b0; bus.req_rd = 1'b0; bus.addr = 8'd0; bus.wdata = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_done = 0;
        repeat (20) begin @(negedge clk); idle_done += int'(bus.done); end
        chk("idle_done", idle_done, 0);
        chk("idle_cs_n", bus.cs_n, 1);
        chk("idle_rd_n", bus.rd_n, 1);
        chk("idle_wr_n", bus.wr_n, 1);
        chk("idle_ad_oe", bus.ad_oe, 0);
        chk("idle_busy", bus.busy, 0);

        run_txn(1, 0, 8'h21, 8'h45, -1, LW + TG + 40, wa, wd, rl, rloe, dn, dat, bf, csf, rdd, erd);
        chk("wr_cs_fall", csf, 0);
        chk("wr_addr_strobe", wa, VFY ? 16 : 8);
        chk("wr_data_strobe", wd, 8);
        chk("wr_done_at", dat, VFY ? 64 : 32);
        chk("wr_busy_fall", bf, VFY ? 74 : 42);
        chk("wr_done_cnt", dn, 1);

        run_txn(0, 1, 8'h22, 8'h00, -1, LR + TG + 40, wa, wd, rl, rloe, dn, dat, bf, csf, rdd, erd);
        chk("rd_strobe", rl, 8);
        chk("rd_oe_overlap", rloe, 0);
        chk("rd_addr_strobe", wa, 8);
        chk("rd_done_at", dat, 32);
        chk("rd_rdata", rdd, 8'h59);

        run_txn(1, 1, 8'h23, 8'h10, 9, LW + TG + 40, wa, wd, rl, rloe, dn, dat, bf, csf, rdd, erd);
        chk("both_rd_strobe", rl, VFY ? 8 : 0);
        chk("both_data_strobe", wd, 8);
        chk("both_done_cnt", dn, 1);

        bus.req_wr = 1'b1; bus.addr = 8'h21; bus.wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bus.req_wr = 1'b0;
        repeat (24) @(negedge clk);
        chk("abort_pre_wr_n", bus.wr_n, 0);
        #2 reset = 1'b1;
        #1;
        chk("abort_wr_n", bus.wr_n, 1);
        chk("abort_cs_n", bus.cs_n, 1);
        chk("abort_ad_oe", bus.ad_oe, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_txn(0, 1, 8'h21, 8'h00, -1, LR + TG + 40, wa, wd, rl, rloe, dn, dat, bf, csf, rdd, erd);
        chk("after_abort_done", dn, 1);
        chk("after_abort_rdata", rdd, 8'h45);

`ifdef RTC_BUS_WRITE_VERIFY_EN
        corrupt = 1'b1;
        run_txn(1, 0, 8'h30, 8'h45, -1, LW + TG + 40, wa, wd, rl, rloe, dn, dat, bf, csf, rdd, erd);
        chk("vfy_bad_done_at", dat, 64);
        chk("vfy_bad_rdata", rdd, 8'h44);
        chk("vfy_bad_err", erd, 1);
        corrupt = 1'b0;
        run_txn(1, 0, 8'h31, 8'h45, -1, LW + TG + 40, wa, wd, rl, rloe, dn, dat, bf, csf, rdd, erd);
        chk("vfy_ok_rdata", rdd, 8'h45);
        chk("vfy_ok_err", erd, 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 2000) begin
                bus.req_wr = 1'b0; bus.req_rd = 1'b0;
                for (int t = 0; t < 200 && bus.busy; t++) @(negedge clk);
                chk("idle_wait", bus.busy, 0);
                corrupt = 1'b1;
            end
            rr = int'($urandom_range(0, 19));
            if (i >= 1000 && i < 1300) begin
                bus.req_rd = 1'b1; bus.req_wr = 1'b0;
            end else begin
                bus.req_wr = rr == 0;
                bus.req_rd = rr == 1 || rr == 2;
            end
            bus.addr  = 8'h20 + 8'($urandom_range(0, 7));
            bus.wdata = 8'($urandom);
        end
        bus.req_wr = 1'b0; bus.req_rd = 1'b0;
        repeat (100) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
